// File: rtl/izh_inacc_sequencer_if.sv
// Four-phase event handshake between the event scheduler and the accumulator sequencer.
// The master raises req with a stable event; the slave answers with ack.
interface izh_inacc_sequencer_if;
  logic       req;
  logic       ack;
  logic [1:0] kind;    // 00 exc, 01 inh, 10 leak sweep, 11 reserved
  logic [7:0] neur;
  logic [2:0] weight;

  modport master (output req, output kind, output neur, output weight, input ack);
  modport slave  (input req, input kind, input neur, input weight, output ack);
endinterface

// File: rtl/izh_inacc_sequencer.sv
// Event sequencer: neuron-state SRAM read-modify-write around the combinational Izhikevich
// input accumulator, with one-cycle overflow pulses toward the neuron output logic.
module izh_inacc_sequencer #(
  parameter int unsigned N         = 256,
  parameter int unsigned ACC_DEPTH = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  izh_inacc_sequencer_if.slave evt,
  output logic [ACC_DEPTH-1:0] inacc_state_o,
  output logic [2:0]           inacc_weight_o,
  output logic                 inacc_exc_o,
  output logic                 inacc_inh_o,
  output logic                 inacc_leak_o,
  input  logic [ACC_DEPTH-1:0] inacc_state_next_i,
  input  logic                 ovfl_exc_i,
  input  logic                 ovfl_inh_i,
  input  logic                 ovfl_leak_i,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [7:0]           sram_addr_o,
  output logic [ACC_DEPTH-1:0] sram_wdata_o,
  input  logic [ACC_DEPTH-1:0] sram_rdata_i,
  output logic                 spk_valid_o,
  output logic [7:0]           spk_neur_o,
  output logic [1:0]           spk_type_o,
  output logic                 busy_o
);

  localparam logic [1:0] KindExc  = 2'b00;
  localparam logic [1:0] KindInh  = 2'b01;
  localparam logic [1:0] KindLeak = 2'b10;
  localparam logic [1:0] KindRsvd = 2'b11;
  localparam logic [7:0] LastAddr = 8'(N - 1);

  typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StAck} state_e;

  state_e               state_q;
  logic [1:0]           kind_q;
  logic [2:0]           weight_q;
  logic [7:0]           addr_q;
  logic [ACC_DEPTH-1:0] inacc_state_q;
  logic [ACC_DEPTH-1:0] wdata_q;
  logic                 exc_q, inh_q, leak_q;
  logic                 cs_q, we_q, spk_q, ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      kind_q        <= '0;
      weight_q      <= '0;
      addr_q        <= '0;
      inacc_state_q <= '0;
      wdata_q       <= '0;
      exc_q         <= 1'b0;
      inh_q         <= 1'b0;
      leak_q        <= 1'b0;
      cs_q          <= 1'b0;
      we_q          <= 1'b0;
      spk_q         <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      // Pulse-type outputs are only ever high for the single cycle of their state.
      exc_q  <= 1'b0;
      inh_q  <= 1'b0;
      leak_q <= 1'b0;
      cs_q   <= 1'b0;
      we_q   <= 1'b0;
      spk_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (evt.req) begin
            kind_q   <= evt.kind;
            weight_q <= evt.weight;
            addr_q   <= (evt.kind == KindLeak) ? 8'd0 : evt.neur;
            if (evt.kind == KindRsvd) begin
              ack_q   <= 1'b1;
              state_q <= StAck;
            end else begin
              cs_q    <= 1'b1;
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          exc_q   <= (kind_q == KindExc);
          inh_q   <= (kind_q == KindInh);
          leak_q  <= (kind_q == KindLeak);
          state_q <= StCalc;
        end
        StCalc: begin
          inacc_state_q <= sram_rdata_i;
          wdata_q       <= inacc_state_next_i;
          unique case (kind_q)
            KindExc:  spk_q <= ovfl_exc_i;
            KindInh:  spk_q <= ovfl_inh_i;
            KindLeak: spk_q <= ovfl_leak_i;
            default:  spk_q <= 1'b0;
          endcase
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          state_q <= StWrite;
        end
        StWrite: begin
          if (kind_q == KindLeak && addr_q != LastAddr) begin
            addr_q  <= addr_q + 8'd1;
            cs_q    <= 1'b1;
            state_q <= StRead;
          end else begin
            ack_q   <= 1'b1;
            state_q <= StAck;
          end
        end
        StAck: begin
          if (!evt.req) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data only arrives during CALC; the captured copy keeps the output steady afterwards.
  assign inacc_state_o  = (state_q == StCalc) ? sram_rdata_i : inacc_state_q;
  assign inacc_weight_o = weight_q;
  assign inacc_exc_o    = exc_q;
  assign inacc_inh_o    = inh_q;
  assign inacc_leak_o   = leak_q;
  assign sram_cs_o      = cs_q;
  assign sram_we_o      = we_q;
  assign sram_addr_o    = addr_q;
  assign sram_wdata_o   = wdata_q;
  assign spk_valid_o    = spk_q;
  assign spk_neur_o     = addr_q;
  assign spk_type_o     = kind_q;
  assign busy_o         = (state_q != StIdle);
  assign evt.ack        = ack_q;

endmodule

// File: tb/tb_izh_inacc_sequencer.sv
// Scoreboard bench: SRAM and accumulator stubs around the sequencer, expectations from a
// per-event reference model, monitor compares SRAM traffic and spike pulses as they occur.
module tb_izh_inacc_sequencer;
  localparam int N  = 256;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  izh_inacc_sequencer_if evt ();

  logic [AW-1:0] inacc_state, inacc_state_next, sram_wdata, sram_rdata;
  logic [2:0]    inacc_weight;
  logic          inacc_exc, inacc_inh, inacc_leak;
  logic          ovfl_exc, ovfl_inh, ovfl_leak;
  logic          sram_cs, sram_we, spk_valid, busy;
  logic [7:0]    sram_addr, spk_neur;
  logic [1:0]    spk_type;

  izh_inacc_sequencer #(.N(N), .ACC_DEPTH(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .evt                (evt),
    .inacc_state_o      (inacc_state),
    .inacc_weight_o     (inacc_weight),
    .inacc_exc_o        (inacc_exc),
    .inacc_inh_o        (inacc_inh),
    .inacc_leak_o       (inacc_leak),
    .inacc_state_next_i (inacc_state_next),
    .ovfl_exc_i         (ovfl_exc),
    .ovfl_inh_i         (ovfl_inh),
    .ovfl_leak_i        (ovfl_leak),
    .sram_cs_o          (sram_cs),
    .sram_we_o          (sram_we),
    .sram_addr_o        (sram_addr),
    .sram_wdata_o       (sram_wdata),
    .sram_rdata_i       (sram_rdata),
    .spk_valid_o        (spk_valid),
    .spk_neur_o         (spk_neur),
    .spk_type_o         (spk_type),
    .busy_o             (busy)
  );

  // Environment: synchronous SRAM plus an accumulator stub (leak strength 2).
  logic [AW-1:0] mem [N];
  bit fi_sel = 1'b0;
  initial sram_rdata = '0;
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
    else if (sram_cs)       sram_rdata <= mem[sram_addr];
  end

  always_comb begin
    inacc_state_next = inacc_state;
    if (inacc_exc)       inacc_state_next = inacc_state + AW'(inacc_weight);
    else if (inacc_inh)  inacc_state_next = inacc_state - AW'(inacc_weight);
    else if (inacc_leak) inacc_state_next = inacc_state - AW'(2);
    ovfl_exc  = fi_sel ? inacc_state_next[0] : 1'b1;
    ovfl_inh  = inacc_state_next[1];
    ovfl_leak = fi_sel ? inacc_state_next[2] : 1'b1;
  end

  // Reference model and scoreboard queues.
  int ref_mem [N];
  int exp_rd[$], exp_wa[$], exp_wd[$], exp_sn[$], exp_st[$];
  int checks = 0;
  int failures = 0;
  int cur_kind = 0;
  int cur_w = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int acc_ref(input int k, input int s, input int w);
    case (k)
      0:       return (s + w) % 2048;
      1:       return (s - w + 2048) % 2048;
      default: return (s - 2 + 2048) % 2048;
    endcase
  endfunction

  function automatic int flag_ref(input int k, input int v);
    case (k)
      0:       return fi_sel ? (v & 1) : 1;
      1:       return (v >> 1) & 1;
      default: return fi_sel ? ((v >> 2) & 1) : 1;
    endcase
  endfunction

  task automatic expect_one(input int k, input int a, input int w);
    int v;
    v = acc_ref(k, ref_mem[a], w);
    exp_rd.push_back(a);
    exp_wa.push_back(a);
    exp_wd.push_back(v);
    if (flag_ref(k, v) != 0) begin
      exp_sn.push_back(a);
      exp_st.push_back(k);
    end
    ref_mem[a] = v;
  endtask

  task automatic preload(input int a, input int v);
    mem[a] <= AW'(v);
    ref_mem[a] = v;
  endtask

  // Monitor: every SRAM access, spike pulse and strobe is matched against expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_cs && !sram_we) begin
        if (exp_rd.size() == 0) chk("unexpected_read", int'(sram_addr), -1);
        else chk("read_addr", int'(sram_addr), exp_rd.pop_front());
      end
      if (sram_cs && sram_we) begin
        if (exp_wa.size() == 0) chk("unexpected_write", int'(sram_addr), -1);
        else begin
          chk("write_addr", int'(sram_addr), exp_wa.pop_front());
          chk("write_data", int'(sram_wdata), exp_wd.pop_front());
        end
      end
      if (spk_valid) begin
        chk("spk_with_write", int'(sram_cs && sram_we), 1);
        if (exp_sn.size() == 0) chk("unexpected_spk", int'(spk_neur), -1);
        else begin
          chk("spk_neur", int'(spk_neur), exp_sn.pop_front());
          chk("spk_type", int'(spk_type), exp_st.pop_front());
        end
      end
      if (inacc_exc || inacc_inh || inacc_leak) begin
        chk("strobe", int'({inacc_exc, inacc_inh, inacc_leak}),
            (cur_kind == 0) ? 4 : (cur_kind == 1) ? 2 : 1);
        if (cur_kind != 2) chk("inacc_weight", int'(inacc_weight), cur_w);
      end
    end
  end

  // Issues one event from a negedge and returns at a negedge after ack has fallen.
  task automatic run_event(input int k, input int n, input int w);
    int cycles, exp_lat, hold;
    if (k != 3) begin
      if (k == 2) for (int a = 0; a < N; a++) expect_one(2, a, w);
      else expect_one(k, n, w);
    end
    exp_lat = (k == 3) ? 1 : (k == 2) ? 3 * N + 1 : 4;
    cur_kind = k;
    cur_w = w;
    evt.req = 1'b1;
    evt.kind = 2'(k);
    evt.neur = 8'(n);
    evt.weight = 3'(w);
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    chk("busy_after_accept", int'(busy), 1);
    while (!evt.ack && cycles < 4 * N + 10) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    chk("ack_latency", evt.ack ? cycles : -1, exp_lat);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("ack_hold", int'(evt.ack), 1);
    end
    evt.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ack_release", int'({evt.ack, busy}), 0);
  endtask

  function automatic int out_vec_nonzero();
    return int'(|{evt.ack, busy, sram_cs, sram_we, sram_addr, sram_wdata, spk_valid, spk_neur,
                  spk_type, inacc_exc, inacc_inh, inacc_leak, inacc_weight, inacc_state});
  endfunction

  initial begin
    int v, k, leaks, mism;
    evt.req = 1'b0;
    evt.kind = '0;
    evt.neur = '0;
    evt.weight = '0;
    for (int i = 0; i < N; i++) preload(i, $urandom_range(0, 2047));
    preload(5, 7);
    preload(200, 20);
    repeat (3) @(negedge clk);
    chk("reset_state", out_vec_nonzero(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_event(0, 5, 1);       // 7 + 1 = 8, spike
    run_event(1, 200, 3);     // 20 - 3 = 17, no spike
    run_event(3, 9, 5);       // reserved: no SRAM traffic
    preload(42, 0);
    run_event(0, 42, 7);      // back-to-back, 7 then 14
    run_event(0, 42, 7);
    for (int i = 0; i < N; i++) preload(i, 10);
    run_event(2, 0, 0);       // every address 10 -> 8, 256 spikes

    // Abort a sweep while neuron 100 is being read; req stays high through reset.
    for (int a = 0; a < 100; a++) expect_one(2, a, 0);
    exp_rd.push_back(100);
    cur_kind = 2;
    evt.req = 1'b1;
    evt.kind = 2'd2;
    @(posedge clk);
    repeat (300) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", out_vec_nonzero(), 0);
    chk("abort_pending", exp_rd.size() + exp_wa.size() + exp_sn.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_event(2, 0, 0);       // held req is a fresh event: full sweep from 0

    fi_sel = 1'b1;
    leaks = 0;
    repeat (40) begin
      k = $urandom_range(0, 3);
      if (k == 2 && leaks > 0) k = 0;
      if (k == 2) leaks++;
      run_event(k, $urandom_range(0, N - 1), $urandom_range(0, 7));
    end

    repeat (3) @(negedge clk);
    chk("leftover_expectations", exp_rd.size() + exp_wa.size() + exp_sn.size(), 0);
    mism = 0;
    for (int i = 0; i < N; i++) begin
      v = int'(mem[i]);
      if (v != ref_mem[i]) mism++;
    end
    chk("sram_contents", mism, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
